// File: rtl/rfid_pkg.sv
// Shared RFID definitions: PIE transmit FSM states, default transmit timing,
// receive-side constants and small elaboration-time helpers.
package rfid_pkg;

  // PIE encoder FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DELIM = 3'd1,
    ST_DATA0 = 3'd2,
    ST_RTCAL = 3'd3,
    ST_TRCAL = 3'd4,
    ST_BITS  = 3'd5
  } pie_state_e;

  // Default transmit (reader-to-tag) timing, in clk cycles
  localparam int PIE_DELIM_CYCLES = 12;
  localparam int PIE_PW_CYCLES    = 12;
  localparam int PIE_TARI_CYCLES  = 25;
  localparam int PIE_DATA1_CYCLES = 50;
  localparam int PIE_TRCAL_CYCLES = 100;

  // Receive (tag-to-reader) side constants
  localparam int RX_BLF_DIVIDE     = 8;
  localparam int RX_T1_MIN_CYCLES  = 80;
  localparam int RX_MILLER_M_MAX   = 8;

  // Largest of three integers, used to size counters at elaboration
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/pie_symbol_timer.sv
// PIE symbol timer: counts through one symbol of a given length, flags the
// symbol's final cycle and reports the level/final-cycle status of the NEXT
// cycle so the encoder can drive registered outputs without extra latency.
// The length input is the length of the symbol the next cycle belongs to; it
// is registered internally so the end strobe refers to the current symbol.
module pie_symbol_timer #(
  parameter int CW        = 7,
  parameter int PW_CYCLES = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [CW-1:0] len,
  output logic          sym_end,
  output logic          level_nxt,
  output logic          last_nxt
);

  localparam logic [CW-1:0] PW_L  = CW'(PW_CYCLES);
  localparam logic [CW-1:0] ONE_L = CW'(1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] len_r;
  logic [CW-1:0] cnt_nxt_s;

  // End-of-symbol detection, counter wrap and next-cycle level lookahead
  always_comb begin
    sym_end = (cnt_r == (len_r - ONE_L));
    if (clr || sym_end) begin
      cnt_nxt_s = '0;
    end else begin
      cnt_nxt_s = cnt_r + ONE_L;
    end
    level_nxt = (cnt_nxt_s < (len - PW_L));
    last_nxt  = (cnt_nxt_s == (len - ONE_L));
  end

  // Symbol position and current symbol length registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
      len_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
      len_r <= len;
    end
  end

endmodule

// File: rtl/pie_encoder.sv
// PIE (pulse-interval encoding) frame encoder: emits delimiter, data-0,
// RTcal, optional TRcal, then one symbol per command bit pulled through a
// valid/ready handshake. All outputs are registered.
module pie_encoder
  import rfid_pkg::*;
#(
  parameter int DELIM_CYCLES = PIE_DELIM_CYCLES,
  parameter int PW_CYCLES    = PIE_PW_CYCLES,
  parameter int TARI_CYCLES  = PIE_TARI_CYCLES,
  parameter int DATA1_CYCLES = PIE_DATA1_CYCLES,
  parameter int TRCAL_CYCLES = PIE_TRCAL_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic preamble_sel,
  input  logic in_dat,
  input  logic in_vld,
  input  logic in_last,
  output logic in_rdy,
  output logic out_mod,
  output logic busy,
  output logic done,
  output logic underrun
);

  localparam int MAX_LEN = max3(DELIM_CYCLES, TRCAL_CYCLES, TARI_CYCLES + DATA1_CYCLES);
  localparam int CW      = $clog2(MAX_LEN + 1);

  localparam logic [CW-1:0] LEN_DELIM = CW'(DELIM_CYCLES);
  localparam logic [CW-1:0] LEN_TARI  = CW'(TARI_CYCLES);
  localparam logic [CW-1:0] LEN_DATA1 = CW'(DATA1_CYCLES);
  localparam logic [CW-1:0] LEN_RTCAL = CW'(TARI_CYCLES + DATA1_CYCLES);
  localparam logic [CW-1:0] LEN_TRCAL = CW'(TRCAL_CYCLES);

  // Symbol length belonging to a state (and, in BITS, to the bit value)
  function automatic logic [CW-1:0] sym_len(input pie_state_e st, input logic bit_v);
    logic [CW-1:0] l;
    case (st)
      ST_DELIM: l = LEN_DELIM;
      ST_DATA0: l = LEN_TARI;
      ST_RTCAL: l = LEN_RTCAL;
      ST_TRCAL: l = LEN_TRCAL;
      ST_BITS:  l = bit_v ? LEN_DATA1 : LEN_TARI;
      default:  l = LEN_DELIM;
    endcase
    return l;
  endfunction

  pie_state_e    state_r, state_n_s;
  logic          pre_r, pre_n_s;
  logic          bit_r, bit_n_s;
  logic          last_r, last_n_s;
  logic          done_n_s, underrun_n_s;
  logic          out_mod_n_s, in_rdy_n_s;
  logic          out_mod_r, in_rdy_r, busy_r, done_r, underrun_r;
  logic [CW-1:0] len_n_s;
  logic          clr_s;
  logic          sym_end_s, level_nxt_s, last_nxt_s;

  pie_symbol_timer #(
    .CW        (CW),
    .PW_CYCLES (PW_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr_s),
    .len       (len_n_s),
    .sym_end   (sym_end_s),
    .level_nxt (level_nxt_s),
    .last_nxt  (last_nxt_s)
  );

  // Next-state, latched frame context and next-cycle output decode
  always_comb begin
    state_n_s    = state_r;
    pre_n_s      = pre_r;
    bit_n_s      = bit_r;
    last_n_s     = last_r;
    done_n_s     = 1'b0;
    underrun_n_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_n_s = ST_DELIM;
          pre_n_s   = preamble_sel;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_DELIM: begin
        if (sym_end_s) begin
          state_n_s = ST_DATA0;
        end else begin
          state_n_s = ST_DELIM;
        end
      end
      ST_DATA0: begin
        if (sym_end_s) begin
          state_n_s = ST_RTCAL;
        end else begin
          state_n_s = ST_DATA0;
        end
      end
      ST_RTCAL, ST_TRCAL, ST_BITS: begin
        if (!sym_end_s) begin
          state_n_s = state_r;
        end else if ((state_r == ST_RTCAL) && pre_r) begin
          state_n_s = ST_TRCAL;
        end else if ((state_r == ST_BITS) && last_r) begin
          state_n_s = ST_IDLE;
          done_n_s  = 1'b1;
        end else if (in_vld) begin
          // in_rdy is high on this cycle: accept the next bit
          state_n_s = ST_BITS;
          bit_n_s   = in_dat;
          last_n_s  = in_last;
        end else begin
          state_n_s    = ST_IDLE;
          underrun_n_s = 1'b1;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase

    len_n_s = sym_len(state_n_s, bit_n_s);
    clr_s   = (state_r == ST_IDLE);

    case (state_n_s)
      ST_IDLE:  out_mod_n_s = 1'b1;
      ST_DELIM: out_mod_n_s = 1'b0;
      default:  out_mod_n_s = level_nxt_s;
    endcase

    in_rdy_n_s = last_nxt_s &&
                 (((state_n_s == ST_RTCAL) && !pre_n_s) ||
                  (state_n_s == ST_TRCAL) ||
                  ((state_n_s == ST_BITS) && !last_n_s));
  end

  // State, frame context and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      pre_r      <= 1'b0;
      bit_r      <= 1'b0;
      last_r     <= 1'b0;
      out_mod_r  <= 1'b1;
      in_rdy_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      pre_r      <= pre_n_s;
      bit_r      <= bit_n_s;
      last_r     <= last_n_s;
      out_mod_r  <= out_mod_n_s;
      in_rdy_r   <= in_rdy_n_s;
      busy_r     <= (state_n_s != ST_IDLE);
      done_r     <= done_n_s;
      underrun_r <= underrun_n_s;
    end
  end

  assign out_mod  = out_mod_r;
  assign in_rdy   = in_rdy_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign underrun = underrun_r;

endmodule

// File: tb/tb_pie_encoder.sv
// Self-checking bench for pie_encoder: builds each frame's expected waveform
// from symbol lengths and compares out_mod/in_rdy/busy/done/underrun per cycle.
module tb_pie_encoder;

  localparam int DELIM = 3;
  localparam int PW    = 2;
  localparam int TARI  = 4;
  localparam int DATA1 = 8;
  localparam int TRCAL = 16;

  logic clk = 1'b0;
  logic rst, start, preamble_sel, in_dat, in_vld, in_last;
  logic in_rdy, out_mod, busy, done, underrun;

  int errors = 0;
  int checks = 0;

  pie_encoder #(
    .DELIM_CYCLES (DELIM),
    .PW_CYCLES    (PW),
    .TARI_CYCLES  (TARI),
    .DATA1_CYCLES (DATA1),
    .TRCAL_CYCLES (TRCAL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .preamble_sel (preamble_sel),
    .in_dat       (in_dat),
    .in_vld       (in_vld),
    .in_last      (in_last),
    .in_rdy       (in_rdy),
    .out_mod      (out_mod),
    .busy         (busy),
    .done         (done),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_out, input logic e_rdy,
                           input logic e_busy, input logic e_done, input logic e_ur);
    check({tag, ".out_mod"}, out_mod, e_out);
    check({tag, ".in_rdy"}, in_rdy, e_rdy);
    check({tag, ".busy"}, busy, e_busy);
    check({tag, ".done"}, done, e_done);
    check({tag, ".underrun"}, underrun, e_ur);
  endtask

  // Runs one frame. u: index of the bit withheld (underrun), -1 for none.
  // rst_at: frame cycle at which reset is applied, -1 for none.
  // noise: toggle start/in_vld/in_dat randomly outside request cycles.
  task automatic run_frame(input logic pre, input int n, input logic [7:0] bits,
                           input int u, input int rst_at, input logic noise);
    int   lens[$];
    logic reqs[$];
    logic exp_out[$];
    logic exp_rdy[$];
    int   k;
    logic aborted;

    // Symbol list straight from the frame definition
    lens.push_back(TARI);          reqs.push_back(1'b0);
    lens.push_back(TARI + DATA1);  reqs.push_back(!pre);
    if (pre) begin
      lens.push_back(TRCAL);       reqs.push_back(1'b1);
    end
    aborted = 1'b0;
    for (int b = 0; b < n; b++) begin
      if (b == u) begin
        aborted = 1'b1;
        break;
      end
      lens.push_back(bits[b] ? DATA1 : TARI);
      reqs.push_back(b < n - 1);
    end

    // Expand into per-cycle expectations
    for (int i = 0; i < DELIM; i++) begin
      exp_out.push_back(1'b0);
      exp_rdy.push_back(1'b0);
    end
    for (int s = 0; s < lens.size(); s++) begin
      for (int c = 0; c < lens[s]; c++) begin
        exp_out.push_back(c < lens[s] - PW);
        exp_rdy.push_back(reqs[s] && (c == lens[s] - 1));
      end
    end

    // Start request in IDLE
    @(posedge clk); #1;
    start = 1'b1; preamble_sel = pre; in_vld = 1'b0;
    @(negedge clk);
    check_all("idle_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    k = 0;
    for (int t = 0; t < exp_out.size(); t++) begin
      @(posedge clk); #1;
      start        = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      preamble_sel = 1'($urandom_range(0, 1));
      if (exp_rdy[t]) begin
        in_vld  = (k != u);
        in_dat  = (k != u) ? bits[k] : 1'($urandom_range(0, 1));
        in_last = (k == n - 1);
        k++;
      end else begin
        in_vld  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        in_dat  = 1'($urandom_range(0, 1));
        in_last = 1'($urandom_range(0, 1));
      end
      if (t == rst_at) rst = 1'b1;
      @(negedge clk);
      check_all("frame", exp_out[t], exp_rdy[t], 1'b1, 1'b0, 1'b0);
      if (t == rst_at) begin
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; in_vld = 1'b0;
        @(negedge clk);
        check_all("after_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        return;
      end
    end

    // Completion cycle: pulse and CW, then pulse gone
    @(posedge clk); #1;
    start = 1'b0; in_vld = 1'b0;
    @(negedge clk);
    check_all("frame_end", 1'b1, 1'b0, 1'b0, !aborted, aborted);
    @(posedge clk); #1;
    @(negedge clk);
    check_all("post_end", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] rbits;
    int         rn, ru;
    logic       rpre;

    rst = 1'b1; start = 1'b0; preamble_sel = 1'b0;
    in_dat = 1'b0; in_vld = 1'b0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Frame-sync, bits 1,0 with last on the 0
    run_frame(1'b0, 2, 8'b0000_0001, -1, -1, 1'b0);
    // Preamble, single bit 1 last
    run_frame(1'b1, 1, 8'b0000_0001, -1, -1, 1'b0);
    // Missing data at the request right after RTcal
    run_frame(1'b0, 2, 8'b0000_0011, 0, -1, 1'b0);
    // Reset in the middle of TRcal, then a clean frame
    run_frame(1'b1, 3, 8'b0000_0101, -1, DELIM + TARI + TARI + DATA1 + 6, 1'b0);
    run_frame(1'b1, 2, 8'b0000_0010, -1, -1, 1'b0);
    // Start pulses and in_vld chatter during the frame must be ignored
    run_frame(1'b0, 4, 8'b0000_1011, -1, -1, 1'b1);

    // Randomized frames
    for (int r = 0; r < 12; r++) begin
      rpre  = 1'($urandom_range(0, 1));
      rn    = $urandom_range(1, 6);
      rbits = 8'($urandom);
      ru    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, rn - 1) : -1;
      run_frame(rpre, rn, rbits, ru, -1, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pie_encoder.md
PIE_ENCODER -- requirements
Module: pie_encoder

Interface
REQ-001 SHALL have parameter DELIM_CYCLES, default 12, delimiter low time in clk cycles.
REQ-002 SHALL have parameter PW_CYCLES, default 12, PIE low pulse width closing every symbol.
REQ-003 SHALL have parameter TARI_CYCLES, default 25, data-0 symbol length.
REQ-004 SHALL have parameter DATA1_CYCLES, default 50, data-1 symbol length.
REQ-005 SHALL have parameter TRCAL_CYCLES, default 100, TRcal symbol length.
REQ-006 SHALL have port clk, input, 1, clock.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port start, input, 1, frame start request, honoured only when idle.
REQ-009 SHALL have port preamble_sel, input, 1, sampled with start: 1 selects preamble (with TRcal), 0 selects frame-sync.
REQ-010 SHALL have port in_dat, input, 1, command bit to encode.
REQ-011 SHALL have port in_vld, input, 1, in_dat valid.
REQ-012 SHALL have port in_last, input, 1, marks final bit of frame, qualified by in_vld.
REQ-013 SHALL have port in_rdy, output, 1, bit accepted when in_vld and in_rdy are both high.
REQ-014 SHALL have port out_mod, output, 1, registered modulator drive: 1 = full carrier, 0 = attenuated.
REQ-015 SHALL have port busy, output, 1, high from the cycle after start acceptance until the return to IDLE.
REQ-016 SHALL have port done, output, 1, one-cycle pulse on normal frame completion.
REQ-017 SHALL have port underrun, output, 1, one-cycle pulse on frame abort due to missing data.

Function
REQ-018 FSM states SHALL be IDLE, DELIM, DATA0, RTCAL, TRCAL, BITS.
REQ-019 IDLE SHALL drive out_mod=1 (CW); start in IDLE SHALL latch preamble_sel and enter DELIM; out_mod=0 from the next cycle.
REQ-020 DELIM SHALL hold out_mod=0 for exactly DELIM_CYCLES cycles, then enter DATA0.
REQ-021 Each symbol of length L SHALL drive out_mod=1 for L-PW_CYCLES cycles, then 0 for PW_CYCLES cycles, with no gap between consecutive symbols.
REQ-022 DATA0 SHALL use L=TARI_CYCLES; RTCAL SHALL use L=TARI_CYCLES+DATA1_CYCLES; TRCAL SHALL use L=TRCAL_CYCLES; in BITS L SHALL be TARI_CYCLES for bit 0 and DATA1_CYCLES for bit 1.
REQ-023 RTCAL SHALL be followed by TRCAL if preamble_sel was latched high, otherwise by BITS.
REQ-024 in_rdy SHALL be high only on the final cycle of RTCAL (frame-sync), of TRCAL (preamble), or of a BITS symbol whose bit did not have in_last set.
REQ-025 A handshake SHALL latch in_dat and in_last; the next cycle SHALL start that bit's symbol.
REQ-026 If in_vld is low while in_rdy is high, the block SHALL pulse underrun, enter IDLE, and drive out_mod=1 on the next cycle.
REQ-027 After the final cycle of the symbol for a bit with in_last set, the block SHALL pulse done, enter IDLE, and drive out_mod=1 on the next cycle.
REQ-028 start while busy SHALL be ignored; in_vld outside in_rdy cycles SHALL be ignored.
REQ-029 The symbol counter width SHALL be $clog2(max(DELIM_CYCLES,TRCAL_CYCLES,TARI_CYCLES+DATA1_CYCLES)+1); the counter SHALL wrap to 0 on each symbol end.
REQ-030 Parameters SHALL satisfy PW_CYCLES < TARI_CYCLES <= DATA1_CYCLES and TRCAL_CYCLES > PW_CYCLES; violations are unsupported.

Reset
REQ-031 rst SHALL force IDLE on the next edge, including mid-frame, with out_mod=1 and in_rdy, busy, done, underrun all 0.
REQ-032 rst SHALL clear the symbol counter and the latched preamble_sel, bit, and last flag.

Structure
REQ-033 State encodings and default timing constants SHALL be placed in shared package rfid_pkg, alongside the receive-side constants.
REQ-034 A sub-module pie_symbol_timer SHALL take a length, produce the high/low level and an end-of-symbol strobe, and be instantiated once.

Verification (bench parameters: DELIM=3, PW=2, TARI=4, DATA1=8, TRCAL=16)
REQ-035 Frame-sync, bits 1,0 (last on 0) -> out_mod after start: 000 11 00 1111111111 00 111111 00 11 00 1, then done pulse and busy low.
REQ-036 Preamble, single bit 1 last -> RTcal (10 high, 2 low), then TRcal (14 high, 2 low), then 6 high, 2 low, then done.
REQ-037 in_vld low at the in_rdy cycle after RTcal -> underrun pulse, out_mod=1 next cycle, no done.
REQ-038 rst asserted mid-TRcal -> out_mod=1 and busy=0 on the next cycle; a following start produces a clean frame.
REQ-039 start pulsed during BITS and in_vld held high continuously -> exactly one bit consumed per symbol; frame unaffected.
